mem_arbiter: RTL and testbench

Shares one multi-cycle, pipelined, single-port main memory between the I-side cache fill path and the D-side cache fill/write path. It sequences a full cache-line read burst for a granted requester and steers returned words back with word indices. It also performs single-word D-side write-through. The block sits between the I-cache and D-cache miss controllers and the main memory instance in the CPU top level.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_fill.sv | 76 +++++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the memory arbiter slice: FSM state and owner
// encodings, cache-line geometry and the round-robin grant helper.
// No ports (package).
package mem_arbiter_pkg;

    localparam int LINE_WORDS    = 8;
    localparam int LINE_OFF_BITS = 4;
    localparam int IDX_W         = $clog2(LINE_WORDS);
    localparam int MEM_LAT       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_WRITE = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // A lone request wins outright; on a tie the side that did not own the
    // memory most recently goes first, so neither side can starve.
    function automatic owner_e pick_owner(input logic   i_req,
                                          input logic   d_req,
                                          input owner_e last_owner);
        if (i_req && d_req) begin
            return (last_owner == OWN_I) ? OWN_D : OWN_I;
        end
        return d_req ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_fill.sv
// fill_sequencer
// Sequences one cache-line read burst: issues LINE_WORDS consecutive reads
// starting at the line base and tags each returned word with its index.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start_i         begin a new burst (counters cleared on this edge)
//   base_i          line-aligned base byte address, held for the burst
//   mem_rvalid_i    memory read data valid
//   mem_en_o        read issue strobe
//   mem_addr_o      byte address of the current issue (0 when idle)
//   word_idx_o      index of the returning word (0 when none)
//   word_valid_o    a word of this burst returns this cycle
//   last_o          the returning word is the final one of the line
module fill_sequencer
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              mem_rvalid_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [IDX_W-1:0]  word_idx_o,
    output logic              word_valid_o,
    output logic              last_o
);

    logic             busy_q, busy_d;
    logic [IDX_W:0]   issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0] ret_cnt_q, ret_cnt_d;

    // Returns are only accepted while a burst is live; busy drops with the
    // last word, so stray or late mem_rvalid pulses fall on the floor.
    always_comb begin
        mem_en_o     = busy_q && (issue_cnt_q < (IDX_W+1)'(LINE_WORDS));
        mem_addr_o   = mem_en_o ? (base_i + ADDR_W'({issue_cnt_q, 1'b0})) : '0;
        word_valid_o = busy_q && mem_rvalid_i;
        word_idx_o   = word_valid_o ? ret_cnt_q : '0;
        last_o       = word_valid_o && (ret_cnt_q == IDX_W'(LINE_WORDS - 1));

        busy_d      = busy_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (start_i) begin
            busy_d      = 1'b1;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end else begin
            if (mem_en_o) begin
                issue_cnt_d = issue_cnt_q + (IDX_W+1)'(1);
            end
            if (word_valid_o) begin
                ret_cnt_d = ret_cnt_q + IDX_W'(1);
            end
            if (last_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one pipelined single-port memory between the I-side line fill and
// the D-side line fill / single-word write-through path.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_req, i_addr                     I-side line-fill request and address
//   i_data_valid, i_word_idx, i_done  I-side returned word strobe/index/done
//   d_req, d_wr, d_addr, d_wdata      D-side request, write select, addr, data
//   d_data_valid, d_word_idx, d_done  D-side returned word strobe/index/done
//   fill_data                         returned word (0 unless a word returns)
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                         memory command
//   mem_rdata, mem_rvalid             memory read return
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_data_valid,
    output logic [IDX_W-1:0]  i_word_idx,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_data_valid,
    output logic [IDX_W-1:0]  d_word_idx,
    output logic              d_done,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFF_BITS) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            gnt_owner;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              seq_start;
    logic              seq_mem_en;
    logic [ADDR_W-1:0] seq_addr;
    logic [IDX_W-1:0]  seq_idx;
    logic              seq_valid;
    logic              seq_last;
    logic              in_write;

    fill_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .start_i      (seq_start),
        .base_i       (base_q),
        .mem_rvalid_i (mem_rvalid),
        .mem_en_o     (seq_mem_en),
        .mem_addr_o   (seq_addr),
        .word_idx_o   (seq_idx),
        .word_valid_o (seq_valid),
        .last_o       (seq_last)
    );

    // Grant only from IDLE; the owner register doubles as the round-robin
    // history, so it is updated on every grant including writes.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        seq_start = 1'b0;
        gnt_owner = pick_owner(i_req, d_req, owner_q);
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = gnt_owner;
                    base_d  = ((gnt_owner == OWN_D) ? d_addr : i_addr) & LINE_MASK;
                    if ((gnt_owner == OWN_D) && d_wr) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d   = ST_FILL;
                        seq_start = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (seq_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
        end
    end

    // Sequencer strobes are only ever live in FILL, so steering by owner is
    // enough to keep the non-owner side quiet.
    always_comb begin
        in_write     = (state_q == ST_WRITE);
        mem_en       = seq_mem_en || in_write;
        mem_wr       = in_write;
        mem_addr     = in_write ? (d_addr & WORD_MASK) : seq_addr;
        mem_wdata    = in_write ? d_wdata : '0;
        fill_data    = seq_valid ? mem_rdata : '0;
        i_data_valid = seq_valid && (owner_q == OWN_I);
        i_word_idx   = i_data_valid ? seq_idx : '0;
        i_done       = seq_last && (owner_q == OWN_I);
        d_data_valid = seq_valid && (owner_q == OWN_D);
        d_word_idx   = d_data_valid ? seq_idx : '0;
        d_done       = in_write || (seq_last && (owner_q == OWN_D));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a latency-MEM_LAT memory model, a
// transaction-level reference model compared every cycle, and literal
// expectations for the directed scenarios.
module tb_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_data_valid;
    logic [2:0]        i_word_idx;
    logic              i_done;
    logic              d_req = 1'b0;
    logic              d_wr = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_data_valid;
    logic [2:0]        d_word_idx;
    logic              d_done;
    logic [DATA_W-1:0] fill_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_data_valid (i_data_valid),
        .i_word_idx   (i_word_idx),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_data_valid (d_data_valid),
        .d_word_idx   (d_word_idx),
        .d_done       (d_done),
        .fill_data    (fill_data),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: reads return MEM_LAT cycles after the issue cycle; writes land
    // immediately. strayValid injects an unsolicited return pulse.
    logic [15:0] ram [0:32767];
    logic        issPipe [0:MEM_LAT-1];
    logic [15:0] datPipe [0:MEM_LAT-1];
    logic        issNext = 1'b0;
    logic [15:0] datNext = '0;
    logic        strayValid = 1'b0;
    logic [15:0] strayData = 16'hDEAD;
    logic [15:0] obsIssue[$];
    logic [15:0] obsWords[$];
    int          obsIdx[$];

    assign mem_rvalid = issPipe[MEM_LAT-1] | strayValid;
    assign mem_rdata  = issPipe[MEM_LAT-1] ? datPipe[MEM_LAT-1] : strayData;

    always @(negedge clk) begin
        issNext = mem_en && !mem_wr;
        datNext = ram[mem_addr[15:1]];
        if (mem_en && mem_wr) ram[mem_addr[15:1]] = mem_wdata;
        if (mem_en && !mem_wr) obsIssue.push_back(mem_addr);
        if (i_data_valid || d_data_valid) begin
            obsWords.push_back(fill_data);
            obsIdx.push_back(i_data_valid ? int'(i_word_idx) : int'(d_word_idx));
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = MEM_LAT - 1; k > 0; k--) begin
            issPipe[k] = issPipe[k-1];
            datPipe[k] = datPipe[k-1];
        end
        issPipe[0] = issNext;
        datPipe[0] = datNext;
    end

    // Reference model: a pending-issue address queue and a return count per
    // burst; outputs follow from which transaction is live.
    int          mState = 0;     // 0 idle, 1 line fill, 2 write
    bit          mOwnD = 1'b0;
    logic [15:0] mAddrQ[$];
    int          mRet = 0;
    logic        eEn, eWr, acc, eIV, eDV, eID, eDD;
    logic [15:0] eAddr, eWd, eFD, mBase;
    int          eIdx;

    always @(negedge clk) begin
        eEn = 0; eWr = 0; eAddr = '0; eWd = '0; acc = 0;
        if (mState == 1) begin
            if (mAddrQ.size() > 0) begin
                eEn   = 1;
                eAddr = mAddrQ[0];
            end
            acc = mem_rvalid && (mRet < 8);
        end else if (mState == 2) begin
            eEn = 1; eWr = 1; eAddr = d_addr & 16'hFFFE; eWd = d_wdata;
        end
        eIV  = acc && !mOwnD;
        eDV  = acc && mOwnD;
        eIdx = acc ? mRet : 0;
        eFD  = acc ? mem_rdata : '0;
        eID  = eIV && (mRet == 7);
        eDD  = (eDV && (mRet == 7)) || (mState == 2);
        if (checkEn) begin
            checkOutput("mem_en", mem_en, eEn);
            checkOutput("mem_wr", mem_wr, eWr);
            checkOutput("mem_addr", mem_addr, eAddr);
            checkOutput("mem_wdata", mem_wdata, eWd);
            checkOutput("fill_data", fill_data, eFD);
            checkOutput("i_data_valid", i_data_valid, eIV);
            checkOutput("i_word_idx", i_word_idx, eIV ? eIdx : 0);
            checkOutput("i_done", i_done, eID);
            checkOutput("d_data_valid", d_data_valid, eDV);
            checkOutput("d_word_idx", d_word_idx, eDV ? eIdx : 0);
            checkOutput("d_done", d_done, eDD);
        end
        if (rst) begin
            mState = 0; mOwnD = 0; mRet = 0; mAddrQ.delete();
        end else if (mState == 0) begin
            if (i_req || d_req) begin
                mOwnD = (i_req && d_req) ? !mOwnD : d_req;
                if (mOwnD && d_wr) begin
                    mState = 2;
                end else begin
                    mState = 1;
                    mRet   = 0;
                    mBase  = (mOwnD ? d_addr : i_addr) & 16'hFFF0;
                    for (int k = 0; k < 8; k++) mAddrQ.push_back(mBase + 16'(2 * k));
                end
            end
        end else if (mState == 1) begin
            if (mAddrQ.size() > 0) void'(mAddrQ.pop_front());
            if (acc) begin
                mRet++;
                if (mRet == 8) mState = 0;
            end
        end else begin
            mState = 0;
        end
    end

    task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                 input logic dw, input logic [15:0] da, input logic [15:0] dd);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic waitDone(input bit sideD, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sideD ? d_done : i_done) && n < budget);
        checkOutput(sideD ? "d_done_seen" : "i_done_seen", sideD ? d_done : i_done, 1);
    endtask

    task automatic clearObs();
        obsIssue.delete(); obsWords.delete(); obsIdx.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    int n;
    int cnt;

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 16'(i) ^ 16'h5A00;
        for (int k = 0; k < 8; k++) ram[16'h20 + k] = 16'hA000 + 16'(k);
        for (int k = 0; k < MEM_LAT; k++) begin issPipe[k] = 1'b0; datPipe[k] = '0; end

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_i_done", i_done, 0);
        checkOutput("rst_d_done", d_done, 0);

        // I-side line fill at 0x0046
        $display("[TB] I-side fill");
        @(posedge clk);
        #1;
        rst = 1'b0; i_req = 1'b1; i_addr = 16'h0046;
        clearObs();
        @(posedge clk);
        waitDone(0, 40, n);
        checkOutput("s1_done_latency", n, 12);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("s1_issue_count", obsIssue.size(), 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("s1_addr%0d", k), (k < obsIssue.size()) ? 32'(obsIssue[k]) : 32'hFFFFFFFF, 32'h0040 + 32'(2 * k));
            checkOutput($sformatf("s1_word%0d", k), (k < obsWords.size()) ? 32'(obsWords[k]) : 32'hFFFFFFFF, 32'hA000 + 32'(k));
            checkOutput($sformatf("s1_idx%0d", k), (k < obsIdx.size()) ? 32'(obsIdx[k]) : 32'hFFFFFFFF, 32'(k));
        end

        // D-side write-through
        $display("[TB] D-side write");
        applyStimulus(0, 16'h0, 1, 1, 16'h1235, 16'hBEEF);
        waitDone(1, 10, n);
        checkOutput("s2_latency", n, 2);
        checkOutput("s2_mem_en", mem_en, 1);
        checkOutput("s2_mem_wr", mem_wr, 1);
        checkOutput("s2_mem_addr", mem_addr, 32'h1234);
        checkOutput("s2_mem_wdata", mem_wdata, 32'hBEEF);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        checkOutput("s2_idle_after", mem_en, 0);
        checkOutput("s2_ram", ram[16'h091A], 32'hBEEF);

        // Tie from reset: D first, then I, then D again
        $display("[TB] round-robin ties");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearObs();
        i_req = 1'b1; i_addr = 16'h3008; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        waitDone(1, 40, n);
        checkOutput("s3_first_owner_d", (obsIssue.size() > 0) ? 32'(obsIssue[0]) : 32'hFFFFFFFF, 32'h2000);
        applyStimulus(1, 16'h3008, 0, 0, 16'h0, 16'h0);
        waitDone(0, 40, n);
        checkOutput("s3_loser_latency", n, 13);
        checkOutput("s3_second_i", (obsIssue.size() > 8) ? 32'(obsIssue[8]) : 32'hFFFFFFFF, 32'h3000);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        clearObs();
        applyStimulus(1, 16'h3010, 1, 0, 16'h2010, 16'h0);
        waitDone(1, 40, n);
        checkOutput("s3_tie2_owner_d", (obsIssue.size() > 0) ? 32'(obsIssue[0]) : 32'hFFFFFFFF, 32'h2010);
        applyStimulus(1, 16'h3010, 0, 0, 16'h0, 16'h0);
        waitDone(0, 40, n);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Request dropped mid-burst, then a stray return pulse
        $display("[TB] request drop");
        clearObs();
        applyStimulus(1, 16'h0080, 0, 0, 16'h0, 16'h0);
        for (int t = 0; t < 40 && obsWords.size() < 2; t++) @(posedge clk);
        checkOutput("s4_two_words", obsWords.size() >= 2, 1);
        #1 i_req = 1'b0;
        waitDone(0, 40, n);
        @(posedge clk);
        #1;
        checkOutput("s4_all_words", obsWords.size(), 8);
        strayValid = 1'b1;
        @(negedge clk);
        checkOutput("s4_stray_iv", i_data_valid, 0);
        checkOutput("s4_stray_fd", fill_data, 0);
        @(posedge clk);
        #1 strayValid = 1'b0;

        // Reset in cycle 3 of a D fill
        $display("[TB] reset mid-fill");
        applyStimulus(0, 16'h0, 1, 0, 16'h0100, 16'h0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        n = 0;
        @(negedge clk);
        checkOutput("s5_mem_en", mem_en, 0);
        checkOutput("s5_mem_addr", mem_addr, 0);
        checkOutput("s5_d_done", d_done, 0);
        for (int t = 0; t < 8; t++) begin
            if (t > 0) @(negedge clk);
            if (mem_rvalid) cnt++;
            if (d_data_valid || i_data_valid) n++;
        end
        checkOutput("s5_residual_pulses", cnt, 4);
        checkOutput("s5_residual_ignored", n, 0);
        clearObs();
        applyStimulus(0, 16'h0, 1, 0, 16'h0200, 16'h0);
        waitDone(1, 40, n);
        checkOutput("s5_restart_latency", n, 13);
        checkOutput("s5_restart_idx0", (obsIdx.size() > 0) ? 32'(obsIdx[0]) : 32'hFFFFFFFF, 0);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Top-of-memory line, no wrap
        $display("[TB] address wrap");
        clearObs();
        applyStimulus(1, 16'hFFFA, 0, 0, 16'h0, 16'h0);
        waitDone(0, 40, n);
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("s6_addr%0d", k), (k < obsIssue.size()) ? 32'(obsIssue[k]) : 32'hFFFFFFFF, 32'hFFF0 + 32'(2 * k));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
